// File: rtl/brent_kung_unadd_pkg.sv
// Shared types and default sizing for the digit-serial unadder (operand recovery stage).
package brent_kung_unadd_pkg;

  localparam int WIDTH_DEF  = 12;
  localparam int DIGIT_DEF  = 2;
  localparam int NUM_DIGITS = WIDTH_DEF / DIGIT_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-digit build still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(NUM_DIGITS);

endpackage

// File: rtl/brent_kung_unadd_digit_sub.sv
// Combinational DIGIT-bit subtract with borrow in/out; one slice of the serial borrow chain.
module digit_sub #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             borrow_in,
  output logic [DIGIT-1:0] diff,
  output logic             borrow_out
);

  logic [DIGIT:0] res;

  // The extra top bit wraps to 1 exactly when a - b - borrow_in goes negative.
  assign res = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, borrow_in};
  assign {borrow_out, diff} = res;

endmodule

// File: rtl/brent_kung_unadd.sv
// Digit-serial operand recovery A = SUM - B with inconsistency flag.
// Optional macro UNADD_LOOPBACK_EN adds out_ab (A and B re-interleaved for the adder).
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// CALC  | one DIGIT slice subtracted per cycle, borrow registered
// DONE  | out_valid high, result held until out_ready
module brent_kung_unadd
  import brent_kung_unadd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic             out_err
`ifdef UNADD_LOOPBACK_EN
  ,
  output logic [2*WIDTH-1:0] out_ab
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = idx_width(NDIG);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("brent_kung_unadd: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic             borrow_q;
  logic [WIDTH:0]   sum_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             err_q;

  logic [DIGIT-1:0] diff_d;
  logic             borrow_d;
  int               pos;

  assign pos = int'(idx_q) * DIGIT;

  digit_sub #(.DIGIT(DIGIT)) u_digit_sub (
    .a          (sum_q[pos +: DIGIT]),
    .b          (b_q[pos +: DIGIT]),
    .borrow_in  (borrow_q),
    .diff       (diff_d),
    .borrow_out (borrow_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      sum_q       <= '0;
      b_q         <= '0;
      a_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            sum_q      <= in_sum;
            b_q        <= in_b;
            borrow_q   <= 1'b0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          a_q[pos +: DIGIT] <= diff_d;
          borrow_q          <= borrow_d;
          idx_q             <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            // A carry-out that the final borrow does not cancel means no WIDTH-bit A fits.
            err_q       <= sum_q[WIDTH] ^ borrow_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_a     = a_q;
  assign out_err   = err_q;

`ifdef UNADD_LOOPBACK_EN
  always_comb begin
    out_ab = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_ab[2*i]   = a_q[i];
      out_ab[2*i+1] = b_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_brent_kung_unadd.sv
// Self-checking bench for brent_kung_unadd: vector table, directed corner sequences, random round trips.
module tb_brent_kung_unadd;

  localparam int W    = 12;
  localparam int LAT  = W / 2 + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W:0]    in_sum;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_a;
  logic          out_err;
`ifdef UNADD_LOOPBACK_EN
  logic [2*W-1:0] out_ab;
`endif

  brent_kung_unadd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_err   (out_err)
`ifdef UNADD_LOOPBACK_EN
    ,
    .out_ab    (out_ab)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W:0]   sum;
    logic [W-1:0] a;
    logic         err;
  } exp_t;

  typedef struct {
    logic [W:0]   sum;
    logic [W-1:0] b;
    logic [W-1:0] a;
    logic         err;
  } vec_t;

  exp_t   sb[$];
  exp_t   pend;
  vec_t   vecs[8];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     hs_cyc = 0;
  int     rdy_mode = 0;
  logic   hs = 1'b0;
  logic   hs_pending = 1'b0;
  logic   prev_valid = 1'b0;
  logic   prev_ready = 1'b0;
  logic [W-1:0] prev_a = '0;
  logic   prev_err = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  // Runs at the falling edge: observes what the next rising edge will act on.
  task automatic monitor();
    exp_t e;
    logic [W-1:0] ra, rb;
    if (!rst_n) begin
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_a", int'(out_a), 0);
      check("rst_out_err", int'(out_err), 0);
      sb.delete();
      hs_pending = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      return;
    end
    if (prev_valid && prev_ready) begin
      check("post_hs_out_valid", int'(out_valid), 0);
      check("post_hs_in_ready", int'(in_ready), 1);
    end
    if (out_valid && !prev_valid) begin
      if (hs_pending) check("latency", cyc - hs_cyc, LAT);
      hs_pending = 1'b0;
    end
    if (out_valid && prev_valid && !prev_ready) begin
      check("hold_out_a", int'(out_a), int'(prev_a));
      check("hold_out_err", int'(out_err), int'(prev_err));
    end
    if (out_valid) check("busy_in_ready", int'(in_ready), 0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_a", int'(out_a), int'(e.a));
        check("out_err", int'(out_err), int'(e.err));
`ifdef UNADD_LOOPBACK_EN
        for (int i = 0; i < W; i++) begin
          ra[i] = out_ab[2*i];
          rb[i] = out_ab[2*i+1];
        end
        if (!e.err) check("loopback_sum", int'({1'b0, ra} + {1'b0, rb}), int'(e.sum));
`else
        ra = '0;
        rb = '0;
`endif
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(pend);
      hs = 1'b1;
      hs_cyc = cyc;
      hs_pending = 1'b1;
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_a = out_a;
    prev_err = out_err;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [W:0] s, input logic [W-1:0] bb,
                      input logic [W-1:0] ea, input logic ee);
    pend = '{sum: s, a: ea, err: ee};
    in_sum = s;
    in_b = bb;
    in_valid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 60 && !hs; i++) step();
    if (!hs) fail_now("in_handshake");
    in_valid = 1'b0;
    in_sum = (W+1)'($urandom);
    in_b = W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
  endtask

  task automatic send_model(input logic [W:0] s, input logic [W-1:0] bb);
    int d;
    logic [W-1:0] ea;
    d = int'(s) - int'(bb);
    ea = d[W-1:0];
    send(s, bb, ea, (d < 0) || (d >= (1 << W)));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sum = '0;
    in_b = '0;
    out_ready = 1'b1;

    vecs[0] = '{13'h1000, 12'h001, 12'hFFF, 1'b0};
    vecs[1] = '{13'h0005, 12'h007, 12'hFFE, 1'b1};
    vecs[2] = '{13'h1FFE, 12'hFFF, 12'hFFF, 1'b0};
    vecs[3] = '{13'h1000, 12'h000, 12'h000, 1'b1};
    vecs[4] = '{13'h0A5A, 12'h123, 12'h937, 1'b0};
    vecs[5] = '{13'h1ABC, 12'h123, 12'h999, 1'b1};
    vecs[6] = '{13'h0FFF, 12'hFFF, 12'h000, 1'b0};
    vecs[7] = '{13'h0000, 12'h000, 12'h000, 1'b0};

    repeat (3) step();
    rst_n = 1'b1;
    check("in_ready_at_release", int'(in_ready), 0);
    step();
    check("in_ready_after_reset", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].sum, vecs[i].b, vecs[i].a, vecs[i].err);
      drain();
    end

    // Back-pressure: hold out_ready low for 10 cycles of valid output.
    rdy_mode = 2;
    out_ready = 1'b0;
    send(13'h1234, 12'h0FF, 12'h135, 1'b1);
    for (int i = 0; i < 40 && !out_valid; i++) step();
    repeat (10) step();
    check("bp_valid_held", int'(out_valid), 1);
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_a_held", int'(out_a), 'h135);
    rdy_mode = 0;
    drain();

    // Reset in CALC cycle 3: the in-flight request must never emerge.
    send(13'h0777, 12'h111, 12'h666, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("async_rst_out_a", int'(out_a), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rst2_in_ready", int'(in_ready), 1);
    repeat (12) step();
    check("rst2_no_output", int'(out_valid), 0);
    send(13'h0A5A, 12'h123, 12'h937, 1'b0);
    drain();

    // Random round trips with random back-pressure, then arbitrary sums.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      send({1'b0, ra} + {1'b0, rb}, rb, ra, 1'b0);
      drain();
    end
    for (int i = 0; i < 200; i++) begin
      send_model((W+1)'($urandom), W'($urandom));
      drain();
    end
    rdy_mode = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
